irq_gen: RTL and testbench
==========================

# irq_gen

Machine-level interrupt source feeding the core's CSR unit `interrupt_i[1:0]`. It holds a memory-mapped 64-bit `mtime`/`mtimecmp` timer and an external-interrupt line conditioner with pending latch. It exposes a simple single-cycle register port on the data bus and drives the timer (MTIP) and external (MEIP) pending levels to the CSR unit, which applies `mie` masking and trap entry.

## Interface
- `XLEN`, 32: bus data width; must be 32.
- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `bus_en`  in  1  access strobe, one cycle per access.
- `bus_we`  in  1  1 = write, 0 = read; sampled with `bus_en`.
- `bus_addr`  in  5  byte offset; `bus_addr[4:2]` selects the register, `[1:0]` ignored.
- `bus_wdata`  in  XLEN  write data.
- `bus_rdata`  out  XLEN  read data, valid while `bus_ready`=1, else 0.
- `bus_ready`  out  1  access-complete pulse.
- `ext_irq_i`  in  1  external interrupt request, asynchronous.
- `interrupt_o`  out  2  [0] = MTIP, [1] = MEIP; connects to CSR `interrupt_i`.

## Operation
- Register map (offsets): 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 EXT_STATUS (bit0 pending, W1C), 0x14 EXT_CTRL (bit0 enable, bit1 mode: 0 = level, 1 = rising edge), 0x18 PRESC (bits 15:0). Offset 0x1C reads 0; writes to it are ignored.
- Reset values: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, pending=0, EXT_CTRL=0, PRESC=0, prescale counter=0, hi-shadow=0, `interrupt_o`=2'b00, `bus_ready`=0, `bus_rdata`=0.
- Timer: mtime increments by 1 when the prescale counter equals PRESC. The counter then resets to 0; otherwise it increments. PRESC=0 means mtime increments every cycle.
- mtime wraps from 2^64-1 to 0.
- A bus write to MTIME_LO/HI overrides the increment in that cycle: only the written half is updated, and the other half holds.
- MTIP = (mtime >= mtimecmp), unsigned 64-bit compare, registered into `interrupt_o[0]`.
- Read atomicity: reading MTIME_LO returns mtime[31:0] and copies mtime[63:32] into the hi-shadow in the same cycle. Reading MTIME_HI returns the hi-shadow.
- External line: 2-flop synchronizer, then a registered copy for edge detection.
  - Level mode: pending = synced level & enable, recomputed every cycle; W1C has no lasting effect.
  - Edge mode: pending is set on a synced 0→1 transition while enable=1. W1C of bit0 clears it. Simultaneous set and clear: set wins.
- MEIP = pending & enable, registered into `interrupt_o[1]`.
- Clearing enable drops MEIP on the next cycle. In edge mode, pending is held.

## Timing
- Bus: `bus_en` sampled at edge N; `bus_ready`=1 and `bus_rdata` valid during cycle N+1, for exactly one cycle.
- Write effects are visible from cycle N+1.
- Back-to-back accesses every cycle are supported; there are no wait states.
- MTIP: mtime reaches mtimecmp at edge N, so `interrupt_o[0]`=1 from N+1.
- A write that raises mtimecmp above mtime deasserts MTIP one cycle after the write takes effect.
- MEIP (edge mode): `ext_irq_i` rises before edge N, and `interrupt_o[1]`=1 from N+4 (2 sync, 1 edge/pending, 1 output register).
- `rst` asserted at any edge forces every reset value at that edge. A bus access in the same cycle is discarded, with no `bus_ready`.

## Configuration
- `IRQ_GEN_PRESCALER_EN` defined: PRESC register and prescale counter present, as above.
- Not defined: no counter; mtime increments every cycle; PRESC reads 0 and writes are ignored.

## Structure
- Shared package `irq_gen_pkg`:
  - register offset constants (`IRQ_MTIME_LO` … `IRQ_PRESC`);
  - EXT_CTRL bit indices;
  - the MTIMECMP reset constant;
  - interrupt bit indices (`IRQ_MTIP`=0, `IRQ_MEIP`=1), which the CSR unit also uses.
- One sub-module, `irq_sync`: 2-flop synchronizer plus rising-edge detector with a synchronous reset to 0.

## Test plan
- Reset, then read all registers → MTIME=small running value, MTIMECMP=FFFF_FFFF/FFFF_FFFF, others 0, `interrupt_o`=00.
- Write MTIMECMP_HI=0, then MTIMECMP_LO=100, with PRESC=0 → `interrupt_o[0]` rises exactly one cycle after mtime==100. A later write of MTIMECMP_LO=FFFF_FFFF drops it.
- Write MTIME_LO=FFFF_FFFE, MTIME_HI=FFFF_FFFF → mtime wraps to 0 two cycles later. MTIP stays 1 while compare holds, then drops after the wrap.
- EXT_CTRL=3, pulse `ext_irq_i` high for 1 cycle → `interrupt_o[1]`=1 four cycles later and stays 1. A W1C to EXT_STATUS clears it. A W1C on the same cycle as a new edge leaves pending=1.
- EXT_CTRL=1 (level): hold `ext_irq_i` 10 cycles → MEIP follows with 3-cycle delay; a W1C has no effect.
- PRESC=3 (macro on) → mtime increments every 4 cycles. Macro off → PRESC reads 0 and mtime increments every cycle.

Source files
------------

// File: rtl/irq_gen_pkg.sv
// Shared constants for the machine-level interrupt source: register offsets,
// EXT_CTRL bit positions, the MTIMECMP reset value and the interrupt bit indices.
package irq_gen_pkg;

  localparam logic [4:0] IRQ_MTIME_LO    = 5'h00;
  localparam logic [4:0] IRQ_MTIME_HI    = 5'h04;
  localparam logic [4:0] IRQ_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] IRQ_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] IRQ_EXT_STATUS  = 5'h10;
  localparam logic [4:0] IRQ_EXT_CTRL    = 5'h14;
  localparam logic [4:0] IRQ_PRESC       = 5'h18;

  localparam int EXT_CTRL_EN   = 0;
  localparam int EXT_CTRL_MODE = 1;  // 0 = level, 1 = rising edge

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam int IRQ_MTIP = 0;
  localparam int IRQ_MEIP = 1;

  // Word index (offset[4:2]) of each register.
  typedef enum logic [2:0] {
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_MTIMECMP_LO,
    REG_MTIMECMP_HI,
    REG_EXT_STATUS,
    REG_EXT_CTRL,
    REG_PRESC,
    REG_RSVD
  } reg_sel_e;

  function automatic reg_sel_e reg_sel(input logic [4:0] addr);
    return reg_sel_e'(addr[4:2]);
  endfunction

endpackage

// File: rtl/irq_gen_sync.sv
// irq_sync: two-flop synchronizer for an asynchronous request line, followed by
// a registered copy that yields a one-cycle rising-edge indication.
module irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_level,
  output logic sync_rise
);

  logic [1:0] stage_reg;
  logic       prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= 2'b00;
      prev_reg  <= 1'b0;
    end else begin
      stage_reg <= {stage_reg[0], async_in};
      prev_reg  <= stage_reg[1];
    end
  end

  assign sync_level = stage_reg[1];
  assign sync_rise  = stage_reg[1] & ~prev_reg;

endmodule

// File: rtl/irq_gen.sv
// irq_gen: 64-bit mtime/mtimecmp timer plus external-interrupt conditioner,
// driving MTIP/MEIP levels. Define IRQ_GEN_PRESCALER_EN to add the PRESC register.
module irq_gen
  import irq_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bus_en,
  input  logic            bus_we,
  input  logic [4:0]      bus_addr,
  input  logic [XLEN-1:0] bus_wdata,
  output logic [XLEN-1:0] bus_rdata,
  output logic            bus_ready,
  input  logic            ext_irq_i,
  output logic [1:0]      interrupt_o
);

  logic [63:0]     mtime_reg, mtime_next;
  logic [63:0]     mtimecmp_reg, mtimecmp_next;
  logic [31:0]     shadow_reg, shadow_next;
  logic [1:0]      ctrl_reg, ctrl_next;
  logic            pend_reg, pend_next, pend_eff;
  logic            mtip_reg, meip_reg, ready_reg;
  logic [XLEN-1:0] rdata_reg, rdata_next;
  logic [XLEN-1:0] presc_rd;
  logic            tick;
  logic            wr, rd, w1c;
  logic            sync_level, sync_rise;
  logic            addr_lsb_unused;
  reg_sel_e        sel;

  assign sel             = reg_sel(bus_addr);
  assign wr              = bus_en & bus_we;
  assign rd              = bus_en & ~bus_we;
  assign w1c             = wr && (sel == REG_EXT_STATUS) && bus_wdata[0];
  assign addr_lsb_unused = ^bus_addr[1:0];

  irq_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (ext_irq_i),
    .sync_level (sync_level),
    .sync_rise  (sync_rise)
  );

`ifdef IRQ_GEN_PRESCALER_EN
  logic [15:0] presc_reg, presc_next, cnt_reg, cnt_next;

  always_comb begin
    presc_next = presc_reg;
    if (wr && sel == REG_PRESC) presc_next = bus_wdata[15:0];
    tick     = (cnt_reg == presc_reg);
    cnt_next = tick ? 16'd0 : cnt_reg + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg <= 16'd0;
      cnt_reg   <= 16'd0;
    end else begin
      presc_reg <= presc_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign presc_rd = XLEN'(presc_reg);
`else
  assign tick     = 1'b1;
  assign presc_rd = '0;
`endif

  // Level mode tracks the synced line directly; edge mode uses the sticky latch.
  assign pend_eff = ctrl_reg[EXT_CTRL_MODE] ? pend_reg
                                            : (sync_level & ctrl_reg[EXT_CTRL_EN]);

  always_comb begin
    mtime_next    = mtime_reg + 64'(tick);
    mtimecmp_next = mtimecmp_reg;
    shadow_next   = shadow_reg;
    ctrl_next     = ctrl_reg;
    rdata_next    = '0;

    // A write to one mtime half suppresses that cycle's increment.
    if (wr) begin
      case (sel)
        REG_MTIME_LO:    mtime_next    = {mtime_reg[63:32], bus_wdata};
        REG_MTIME_HI:    mtime_next    = {bus_wdata, mtime_reg[31:0]};
        REG_MTIMECMP_LO: mtimecmp_next = {mtimecmp_reg[63:32], bus_wdata};
        REG_MTIMECMP_HI: mtimecmp_next = {bus_wdata, mtimecmp_reg[31:0]};
        REG_EXT_CTRL:    ctrl_next     = bus_wdata[1:0];
        default: ;
      endcase
    end

    if (rd) begin
      case (sel)
        REG_MTIME_LO: begin
          rdata_next  = mtime_reg[31:0];
          shadow_next = mtime_reg[63:32];
        end
        REG_MTIME_HI:    rdata_next = shadow_reg;
        REG_MTIMECMP_LO: rdata_next = mtimecmp_reg[31:0];
        REG_MTIMECMP_HI: rdata_next = mtimecmp_reg[63:32];
        REG_EXT_STATUS:  rdata_next = XLEN'(pend_eff);
        REG_EXT_CTRL:    rdata_next = XLEN'(ctrl_reg);
        REG_PRESC:       rdata_next = presc_rd;
        default:         rdata_next = '0;
      endcase
    end

    // New edge beats a simultaneous W1C.
    if (ctrl_reg[EXT_CTRL_MODE])
      pend_next = (sync_rise & ctrl_reg[EXT_CTRL_EN]) | (pend_reg & ~w1c);
    else
      pend_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_reg    <= 64'd0;
      mtimecmp_reg <= MTIMECMP_RST;
      shadow_reg   <= 32'd0;
      ctrl_reg     <= 2'b00;
      pend_reg     <= 1'b0;
      mtip_reg     <= 1'b0;
      meip_reg     <= 1'b0;
      ready_reg    <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      mtime_reg    <= mtime_next;
      mtimecmp_reg <= mtimecmp_next;
      shadow_reg   <= shadow_next;
      ctrl_reg     <= ctrl_next;
      pend_reg     <= pend_next;
      mtip_reg     <= (mtime_reg >= mtimecmp_reg);
      meip_reg     <= pend_eff & ctrl_reg[EXT_CTRL_EN];
      ready_reg    <= bus_en;
      rdata_reg    <= rdata_next;
    end
  end

  assign bus_ready             = ready_reg;
  assign bus_rdata             = rdata_reg;
  assign interrupt_o[IRQ_MTIP] = mtip_reg;
  assign interrupt_o[IRQ_MEIP] = meip_reg;

endmodule

// File: tb/tb_irq_gen.sv
// Self-checking bench for irq_gen: directed scenarios plus a randomized run
// against a cycle-level reference model built from the register behaviour.
module tb_irq_gen;
  import irq_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_en, bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ready;
  logic        ext_irq_i;
  logic [1:0]  interrupt_o;

  always #5 clk = ~clk;

  irq_gen #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_en     (bus_en),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ready  (bus_ready),
    .ext_irq_i  (ext_irq_i),
    .interrupt_o(interrupt_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [63:0] m_time, m_cmp;
  logic [31:0] m_shadow, m_rdata;
  logic [1:0]  m_ctrl;
  logic [15:0] m_presc, m_cnt;
  logic        m_pend, m_ready, m_mtip, m_meip;
  bit          ext_q[$];  // ext samples of the last three edges, oldest first

  function automatic void model_reset();
    m_time = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_shadow = 32'd0;
    m_ctrl = 2'b00; m_presc = 16'd0; m_cnt = 16'd0; m_pend = 1'b0;
    m_ready = 1'b0; m_rdata = 32'd0; m_mtip = 1'b0; m_meip = 1'b0;
    ext_q.delete();
    repeat (3) ext_q.push_back(1'b0);
  endfunction

  function automatic void model_step();
    logic        lvl, rise, en, mode, pend, inc, wr, rd, w1c;
    logic [2:0]  sel;
    logic [31:0] rd_val;
    logic [63:0] old_time;
    if (rst) begin
      model_reset();
      return;
    end
    lvl  = ext_q[1];
    rise = ext_q[1] & ~ext_q[0];
    en   = m_ctrl[0];
    mode = m_ctrl[1];
    pend = mode ? m_pend : (lvl & en);
    wr   = bus_en & bus_we;
    rd   = bus_en & ~bus_we;
    sel  = bus_addr[4:2];
    w1c  = wr && sel == 3'd4 && bus_wdata[0];
    case (sel)
      3'd0:    rd_val = m_time[31:0];
      3'd1:    rd_val = m_shadow;
      3'd2:    rd_val = m_cmp[31:0];
      3'd3:    rd_val = m_cmp[63:32];
      3'd4:    rd_val = {31'd0, pend};
      3'd5:    rd_val = {30'd0, m_ctrl};
`ifdef IRQ_GEN_PRESCALER_EN
      3'd6:    rd_val = {16'd0, m_presc};
`endif
      default: rd_val = 32'd0;
    endcase
    m_ready = bus_en;
    m_rdata = rd ? rd_val : 32'd0;
    m_mtip  = (m_time >= m_cmp);
    m_meip  = pend & en;
    if (rd && sel == 3'd0) m_shadow = m_time[63:32];
`ifdef IRQ_GEN_PRESCALER_EN
    inc   = (m_cnt == m_presc);
    m_cnt = inc ? 16'd0 : m_cnt + 16'd1;
`else
    inc = 1'b1;
`endif
    old_time = m_time;
    m_time   = old_time + {63'd0, inc};
    if (wr) begin
      case (sel)
        3'd0: m_time = {old_time[63:32], bus_wdata};
        3'd1: m_time = {bus_wdata, old_time[31:0]};
        3'd2: m_cmp  = {m_cmp[63:32], bus_wdata};
        3'd3: m_cmp  = {bus_wdata, m_cmp[31:0]};
        3'd5: m_ctrl = bus_wdata[1:0];
`ifdef IRQ_GEN_PRESCALER_EN
        3'd6: m_presc = bus_wdata[15:0];
`endif
        default: ;
      endcase
    end
    m_pend = mode ? ((rise & en) | (m_pend & ~w1c)) : 1'b0;
    ext_q.push_back(ext_irq_i);
    void'(ext_q.pop_front());
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
    bus_en = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d, output logic rdy);
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
    tick();
    d = bus_rdata; rdy = bus_ready;
    bus_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_vals [8];
    logic [31:0] d;
    logic        rdy;
    rst = 1'b1; bus_en = 1'b1; bus_we = 1'b0; bus_addr = IRQ_MTIMECMP_LO;
    tick(); tick();
    n_checks++;
    if (interrupt_o !== 2'b00 || bus_ready !== 1'b0 || bus_rdata !== 32'd0)
      $display("FAIL reset_outputs: got irq=%b ready=%b rdata=%h, expected 00/0/0", interrupt_o, bus_ready, bus_rdata);
    else n_pass++;
    rst = 1'b0; bus_en = 1'b0;
    tick();
    exp_vals = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int r = 0; r < 8; r++) begin
      bus_rd(5'(r * 4), d, rdy);
      n_checks++;
      if (r == 0) begin
        if (d !== m_rdata || d > 32'd16 || rdy !== 1'b1)
          $display("FAIL reset_read_mtime_lo: got %h ready=%b, expected %h ready=1", d, rdy, m_rdata);
        else n_pass++;
      end else if (d !== exp_vals[r] || rdy !== 1'b1)
        $display("FAIL reset_read_%0d: got %h ready=%b, expected %h ready=1", r, d, rdy, exp_vals[r]);
      else n_pass++;
      $display("reset read offset %02h -> %h", r * 4, d);
    end
    n_checks++;
    if (interrupt_o !== 2'b00) $display("FAIL reset_irq: got %b expected 00", interrupt_o);
    else n_pass++;
  endtask

  task automatic test_mtip();
    int          hit = -1;
    logic [31:0] d;
    logic        rdy;
    bus_wr(IRQ_MTIMECMP_HI, 32'd0);
    bus_wr(IRQ_MTIMECMP_LO, 32'd100);
    for (int c = 0; c < 200 && hit < 0; c++) begin
      tick();
      if (m_time == 64'd100) hit = c;
    end
    n_checks++;
    if (hit < 0) $display("FAIL mtip_reach: mtime never reached 100 within 200 cycles");
    else n_pass++;
    n_checks++;
    if (interrupt_o[IRQ_MTIP] !== 1'b0) $display("FAIL mtip_early: got %b expected 0", interrupt_o[IRQ_MTIP]);
    else n_pass++;
    tick();
    n_checks++;
    if (interrupt_o[IRQ_MTIP] !== 1'b1) $display("FAIL mtip_rise: got %b expected 1", interrupt_o[IRQ_MTIP]);
    else n_pass++;
    $display("mtip asserted one cycle after mtime==100");
    bus_rd(IRQ_MTIME_LO, d, rdy);
    n_checks++;
    if (d !== 32'd101) $display("FAIL mtip_mtime_read: got %h expected %h", d, 32'd101);
    else n_pass++;
    bus_wr(IRQ_MTIMECMP_LO, 32'hFFFF_FFFF);
    n_checks++;
    if (interrupt_o[IRQ_MTIP] !== 1'b1) $display("FAIL mtip_hold_on_write: got %b expected 1", interrupt_o[IRQ_MTIP]);
    else n_pass++;
    tick();
    n_checks++;
    if (interrupt_o[IRQ_MTIP] !== 1'b0) $display("FAIL mtip_drop: got %b expected 0", interrupt_o[IRQ_MTIP]);
    else n_pass++;
    $display("mtip dropped after mtimecmp_lo=ffffffff");
  endtask

  task automatic test_wrap();
    logic [31:0] lo, hi;
    logic        rdy;
    logic        exp_seq [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bus_wr(IRQ_MTIME_LO, 32'hFFFF_FFFE);
    bus_wr(IRQ_MTIME_HI, 32'hFFFF_FFFF);
    n_checks++;
    if (interrupt_o[IRQ_MTIP] !== exp_seq[0]) $display("FAIL wrap_mtip_0: got %b expected %b", interrupt_o[IRQ_MTIP], exp_seq[0]);
    else n_pass++;
    for (int k = 1; k < 4; k++) begin
      tick();
      n_checks++;
      if (interrupt_o[IRQ_MTIP] !== exp_seq[k])
        $display("FAIL wrap_mtip_%0d: got %b expected %b", k, interrupt_o[IRQ_MTIP], exp_seq[k]);
      else n_pass++;
    end
    bus_rd(IRQ_MTIME_LO, lo, rdy);
    bus_rd(IRQ_MTIME_HI, hi, rdy);
    n_checks++;
    if (lo !== 32'd1 || hi !== 32'd0) $display("FAIL wrap_value: got %h_%h expected 00000000_00000001", hi, lo);
    else n_pass++;
    $display("wrap: mtime after wrap read %h_%h", hi, lo);
  endtask

  task automatic test_edge_irq();
    logic [31:0] d;
    logic        rdy;
    bus_wr(IRQ_EXT_CTRL, 32'd3);
    ext_irq_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      ext_irq_i = 1'b0;
      n_checks++;
      if (interrupt_o[IRQ_MEIP] !== (k >= 4))
        $display("FAIL edge_latency_%0d: got %b expected %b", k, interrupt_o[IRQ_MEIP], (k >= 4));
      else n_pass++;
    end
    repeat (3) tick();
    bus_rd(IRQ_EXT_STATUS, d, rdy);
    n_checks++;
    if (d !== 32'd1 || interrupt_o[IRQ_MEIP] !== 1'b1) $display("FAIL edge_sticky: got status=%h meip=%b expected 1/1", d, interrupt_o[IRQ_MEIP]);
    else n_pass++;
    bus_wr(IRQ_EXT_STATUS, 32'd1);
    tick();
    n_checks++;
    if (interrupt_o[IRQ_MEIP] !== 1'b0) $display("FAIL edge_w1c: got %b expected 0", interrupt_o[IRQ_MEIP]);
    else n_pass++;
    $display("edge: W1C cleared MEIP");
    ext_irq_i = 1'b1;
    tick();
    ext_irq_i = 1'b0;
    tick();
    bus_wr(IRQ_EXT_STATUS, 32'd1);
    tick();
    n_checks++;
    if (interrupt_o[IRQ_MEIP] !== 1'b1) $display("FAIL edge_set_wins: got %b expected 1", interrupt_o[IRQ_MEIP]);
    else n_pass++;
    bus_wr(IRQ_EXT_CTRL, 32'd2);
    tick();
    n_checks++;
    if (interrupt_o[IRQ_MEIP] !== 1'b0) $display("FAIL edge_disable: got %b expected 0", interrupt_o[IRQ_MEIP]);
    else n_pass++;
    bus_rd(IRQ_EXT_STATUS, d, rdy);
    n_checks++;
    if (d !== 32'd1) $display("FAIL edge_pending_held: got %h expected 1", d);
    else n_pass++;
    bus_wr(IRQ_EXT_CTRL, 32'd3);
    tick();
    n_checks++;
    if (interrupt_o[IRQ_MEIP] !== 1'b1) $display("FAIL edge_reenable: got %b expected 1", interrupt_o[IRQ_MEIP]);
    else n_pass++;
    $display("edge: set-wins and enable gating done");
  endtask

  task automatic test_level_irq();
    bus_wr(IRQ_EXT_CTRL, 32'd1);
    tick(); tick();
    n_checks++;
    if (interrupt_o[IRQ_MEIP] !== 1'b0) $display("FAIL level_idle: got %b expected 0", interrupt_o[IRQ_MEIP]);
    else n_pass++;
    for (int t = 1; t <= 16; t++) begin
      ext_irq_i = (t <= 10);
      if (t == 5) begin
        bus_en = 1'b1; bus_we = 1'b1; bus_addr = IRQ_EXT_STATUS; bus_wdata = 32'd1;
      end
      tick();
      bus_en = 1'b0; bus_we = 1'b0;
      n_checks++;
      if (interrupt_o[IRQ_MEIP] !== (t >= 3 && t <= 12))
        $display("FAIL level_follow_%0d: got %b expected %b", t, interrupt_o[IRQ_MEIP], (t >= 3 && t <= 12));
      else n_pass++;
    end
    $display("level: MEIP followed the line, W1C ignored");
  endtask

  task automatic test_presc();
    logic [31:0] d, a, b;
    logic        rdy;
    bus_wr(IRQ_EXT_CTRL, 32'd0);
    bus_wr(IRQ_PRESC, 32'd3);
    bus_rd(IRQ_PRESC, d, rdy);
    bus_rd(IRQ_MTIME_LO, a, rdy);
    repeat (7) tick();
    bus_rd(IRQ_MTIME_LO, b, rdy);
`ifdef IRQ_GEN_PRESCALER_EN
    n_checks++;
    if (d !== 32'd3) $display("FAIL presc_read: got %h expected 3", d);
    else n_pass++;
    n_checks++;
    if (b - a !== 32'd2) $display("FAIL presc_rate: got delta %0d expected 2", b - a);
    else n_pass++;
`else
    n_checks++;
    if (d !== 32'd0) $display("FAIL presc_read: got %h expected 0", d);
    else n_pass++;
    n_checks++;
    if (b - a !== 32'd8) $display("FAIL presc_rate: got delta %0d expected 8", b - a);
    else n_pass++;
`endif
    $display("presc: read %h, mtime delta over 8 cycles %0d", d, b - a);
    bus_wr(IRQ_PRESC, 32'd0);
  endtask

  task automatic test_random();
    logic [34:0] got, exp;
    int          sel;
    int          errs = 0;
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      bus_en    = $urandom_range(0, 1);
      bus_we    = ($urandom_range(0, 3) == 0);
      sel       = $urandom_range(0, 7);
      bus_addr  = {3'(sel), 2'($urandom)};
      bus_wdata = $urandom;
      if (sel == 1 || sel == 3) bus_wdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
      if (sel == 2) bus_wdata = $urandom_range(0, 600);
      if (sel == 6) bus_wdata = $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0) ext_irq_i = ~ext_irq_i;
      tick();
      got = {bus_ready, bus_rdata, interrupt_o};
      exp = {m_ready, m_rdata, m_meip, m_mtip};
      n_checks++;
      if (got !== exp) begin
        errs++;
        $display("FAIL random_cycle_%0d: got ready=%b rdata=%h irq=%b, expected ready=%b rdata=%h irq=%b",
                 c, got[34], got[33:2], got[1:0], exp[34], exp[33:2], exp[1:0]);
      end else n_pass++;
    end
    rst = 1'b0; bus_en = 1'b0; bus_we = 1'b0;
    $display("random: 600 cycles compared, %0d differing", errs);
  endtask

  initial begin
    rst = 1'b1; bus_en = 1'b0; bus_we = 1'b0; bus_addr = 5'd0; bus_wdata = 32'd0; ext_irq_i = 1'b0;
    model_reset();
    test_reset();
    test_mtip();
    test_wrap();
    test_edge_irq();
    test_level_irq();
    test_presc();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
